// File: rtl/seq_detector_param_pkg.sv
// Shared helpers for the parametrised serial pattern detector.
// All functions are evaluated at elaboration time to build constant tables.
package seq_det_pkg;

    function automatic int state_w(int pat_w);
        return $clog2(pat_w + 1);
    endfunction

    // Longest suffix of (first s pattern bits + b) that is a pattern prefix.
    function automatic int next_state(logic [31:0] pattern, int pat_w,
                                      int s, logic b);
        int   res;
        int   lim;
        int   pos;
        logic ok;
        logic c;
        res = 0;
        lim = (s + 1 > pat_w) ? pat_w : s + 1;
        for (int k = 1; k <= lim; k++) begin
            ok = 1'b1;
            for (int j = 0; j < k; j++) begin
                pos = s + 1 - k + j;
                c   = (pos == s) ? b : pattern[pat_w-1-pos];
                if (c != pattern[pat_w-1-j]) ok = 1'b0;
            end
            if (ok) res = k;
        end
        return res;
    endfunction

    function automatic int fail_state(logic [31:0] pattern, int pat_w);
        int   res;
        logic ok;
        res = 0;
        for (int k = 1; k < pat_w; k++) begin
            ok = 1'b1;
            for (int j = 0; j < k; j++) begin
                if (pattern[k-1-j] != pattern[pat_w-1-j]) ok = 1'b0;
            end
            if (ok) res = k;
        end
        return res;
    endfunction

endpackage

// File: rtl/seq_detector_param_if.sv
// Serial stream, counter control and detector outputs.
interface seq_detector_param_if #(
    parameter int CNT_W = 8
);
    logic             in_valid;
    logic             din;
    logic             cnt_clr;
    logic             match;
    logic [CNT_W-1:0] match_cnt;
    logic             cnt_sat;

    modport master (
        output in_valid, din, cnt_clr,
        input  match, match_cnt, cnt_sat
    );

    modport slave (
        input  in_valid, din, cnt_clr,
        output match, match_cnt, cnt_sat
    );
endinterface

// File: rtl/seq_detector_param_sat_counter.sv
// Saturating event counter; a clear that coincides with an event yields 1.
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] count,
    output logic         sat
);
    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    assign sat   = &count_q;
    assign count = count_q;

    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = inc ? W'(1) : '0;
        end else if (inc && !sat) begin
            count_d = count_q + W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) count_q <= '0;
        else     count_q <= count_d;
    end
endmodule

// File: rtl/seq_detector_param.sv
// KMP-style serial pattern detector with Moore/Mealy timing,
// optional overlap and a saturating match counter.
module seq_detector_param
    import seq_det_pkg::*;
#(
    parameter int               PAT_W   = 4,
    parameter logic [PAT_W-1:0] PATTERN = 4'b1101,
    parameter bit               OVERLAP = 1'b1,
    parameter bit               MOORE   = 1'b1,
    parameter int               CNT_W   = 8
) (
    input logic                 clk,
    input logic                 rst,
    seq_detector_param_if.slave bus
);
    localparam int SW = state_w(PAT_W);
    localparam int NS = 1 << SW;
    localparam logic [SW-1:0] S_FULL = SW'(PAT_W);
    localparam logic [SW-1:0] S_FAIL = SW'(fail_state(32'(PATTERN), PAT_W));
    localparam logic [SW-1:0] S_POST = OVERLAP ? S_FAIL : '0;

    logic [SW-1:0] nxt_tbl [NS][2];

    for (genvar s = 0; s < NS; s++) begin : g_s
        for (genvar b = 0; b < 2; b++) begin : g_b
            if (s < PAT_W) begin : g_v
                assign nxt_tbl[s][b] =
                    SW'(next_state(32'(PATTERN), PAT_W, s, 1'(b)));
            end else begin : g_z
                assign nxt_tbl[s][b] = '0;
            end
        end
    end

    logic [SW-1:0] s_q;
    logic [SW-1:0] s_d;
    logic [SW-1:0] base;
    logic [SW-1:0] nxt;
    logic          match_q;
    logic          match_d;
    logic          hit;

    always_comb begin
        base = s_q;
        // Moore parks in the full state; resume from the post-match state.
        if (MOORE && s_q == S_FULL) base = S_POST;
        nxt     = nxt_tbl[base][bus.din];
        hit     = bus.in_valid && (nxt == S_FULL);
        s_d     = s_q;
        match_d = match_q;
        if (bus.in_valid) begin
            s_d     = (!MOORE && hit) ? S_POST : nxt;
            match_d = hit;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s_q     <= '0;
            match_q <= 1'b0;
        end else begin
            s_q     <= s_d;
            match_q <= match_d;
        end
    end

    if (MOORE) begin : g_moore
        assign bus.match = match_q;
    end else begin : g_mealy
        assign bus.match = hit && !rst;
    end

    sat_counter #(.W(CNT_W)) u_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (hit),
        .clr   (bus.cnt_clr),
        .count (bus.match_cnt),
        .sat   (bus.cnt_sat)
    );
endmodule

// File: tb/tb_seq_detector_param.sv
// Scoreboard bench: six detector configurations share one random stream.
module tb_seq_detector_param;
    localparam int NDUT = 6;

    typedef struct packed {
        logic [NDUT-1:0]      m;
        logic [NDUT-1:0][7:0] c;
        logic [NDUT-1:0]      s;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic in_valid = 1'b0;
    logic din = 1'b0;
    logic cnt_clr = 1'b0;

    always #5 clk = ~clk;

    seq_detector_param_if #(.CNT_W(8)) if0 ();
    seq_detector_param_if #(.CNT_W(8)) if1 ();
    seq_detector_param_if #(.CNT_W(8)) if2 ();
    seq_detector_param_if #(.CNT_W(2)) if3 ();
    seq_detector_param_if #(.CNT_W(4)) if4 ();
    seq_detector_param_if #(.CNT_W(3)) if5 ();

    assign if0.in_valid = in_valid; assign if0.din = din; assign if0.cnt_clr = cnt_clr;
    assign if1.in_valid = in_valid; assign if1.din = din; assign if1.cnt_clr = cnt_clr;
    assign if2.in_valid = in_valid; assign if2.din = din; assign if2.cnt_clr = cnt_clr;
    assign if3.in_valid = in_valid; assign if3.din = din; assign if3.cnt_clr = cnt_clr;
    assign if4.in_valid = in_valid; assign if4.din = din; assign if4.cnt_clr = cnt_clr;
    assign if5.in_valid = in_valid; assign if5.din = din; assign if5.cnt_clr = cnt_clr;

    seq_detector_param #(.PAT_W(4), .PATTERN(4'b1101), .OVERLAP(1'b1),
        .MOORE(1'b1), .CNT_W(8)) u0 (.clk(clk), .rst(rst), .bus(if0));
    seq_detector_param #(.PAT_W(4), .PATTERN(4'b1101), .OVERLAP(1'b0),
        .MOORE(1'b1), .CNT_W(8)) u1 (.clk(clk), .rst(rst), .bus(if1));
    seq_detector_param #(.PAT_W(4), .PATTERN(4'b1101), .OVERLAP(1'b1),
        .MOORE(1'b0), .CNT_W(8)) u2 (.clk(clk), .rst(rst), .bus(if2));
    seq_detector_param #(.PAT_W(4), .PATTERN(4'b1101), .OVERLAP(1'b1),
        .MOORE(1'b1), .CNT_W(2)) u3 (.clk(clk), .rst(rst), .bus(if3));
    seq_detector_param #(.PAT_W(6), .PATTERN(6'b110110), .OVERLAP(1'b1),
        .MOORE(1'b1), .CNT_W(4)) u4 (.clk(clk), .rst(rst), .bus(if4));
    seq_detector_param #(.PAT_W(1), .PATTERN(1'b1), .OVERLAP(1'b0),
        .MOORE(1'b0), .CNT_W(3)) u5 (.clk(clk), .rst(rst), .bus(if5));

    logic       mo [NDUT];
    logic [7:0] co [NDUT];
    logic       so [NDUT];

    assign mo[0] = if0.match; assign co[0] = 8'(if0.match_cnt); assign so[0] = if0.cnt_sat;
    assign mo[1] = if1.match; assign co[1] = 8'(if1.match_cnt); assign so[1] = if1.cnt_sat;
    assign mo[2] = if2.match; assign co[2] = 8'(if2.match_cnt); assign so[2] = if2.cnt_sat;
    assign mo[3] = if3.match; assign co[3] = 8'(if3.match_cnt); assign so[3] = if3.cnt_sat;
    assign mo[4] = if4.match; assign co[4] = 8'(if4.match_cnt); assign so[4] = if4.cnt_sat;
    assign mo[5] = if5.match; assign co[5] = 8'(if5.match_cnt); assign so[5] = if5.cnt_sat;

    // Reference configuration: pattern, length, overlap, Moore, counter width.
    logic [31:0] pat [NDUT] = '{32'hD, 32'hD, 32'hD, 32'hD, 32'h36, 32'h1};
    int          pw  [NDUT] = '{4, 4, 4, 4, 6, 1};
    bit          ovl [NDUT] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    bit          moo [NDUT] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    int          cw  [NDUT] = '{8, 8, 8, 2, 4, 3};

    // Model state: accepted-bit history since reset/last non-overlap match.
    logic [31:0] hbits [NDUT];
    int          hlen  [NDUT];
    int          cnt   [NDUT];
    bit          mflag [NDUT];

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;

    function automatic void check(string nm, int act, int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d t=%0t", nm, act, req, $time);
        end
    endfunction

    function automatic bit completes(int i, bit d);
        logic [31:0] h;
        logic [31:0] mask;
        h    = (hbits[i] << 1) | 32'(d);
        mask = (pw[i] >= 32) ? 32'hFFFF_FFFF : ((32'd1 << pw[i]) - 32'd1);
        return (hlen[i] + 1 >= pw[i]) && ((h & mask) == (pat[i] & mask));
    endfunction

    task automatic step(bit r, bit v, bit d, bit c);
        exp_t e;
        bit   ev;
        int   mx;
        @(negedge clk);
        rst = r; in_valid = v; din = d; cnt_clr = c;
        for (int i = 0; i < NDUT; i++) begin
            mx = (1 << cw[i]) - 1;
            if (r) begin
                hbits[i] = '0; hlen[i] = 0; cnt[i] = 0; mflag[i] = 1'b0;
            end
            ev     = !r && v && completes(i, d);
            e.m[i] = moo[i] ? mflag[i] : ev;
            e.c[i] = 8'(cnt[i]);
            e.s[i] = (cnt[i] == mx);
            if (!r) begin
                if (v) begin
                    hbits[i] = (hbits[i] << 1) | 32'(d);
                    if (hlen[i] < 32) hlen[i]++;
                    mflag[i] = ev;
                    if (ev && !ovl[i]) begin
                        hbits[i] = '0; hlen[i] = 0;
                    end
                end
                if (c) cnt[i] = ev ? 1 : 0;
                else if (ev && cnt[i] < mx) cnt[i]++;
            end
        end
        q.push_back(e);
    endtask

    task automatic bits(logic [31:0] v, int n);
        for (int k = n - 1; k >= 0; k--) step(1'b0, 1'b1, v[k], 1'b0);
    endtask

    task automatic do_reset();
        step(1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (q.size() != 0) begin
                e = q.pop_front();
                for (int i = 0; i < NDUT; i++) begin
                    check($sformatf("match[%0d]", i), int'(mo[i]), int'(e.m[i]));
                    check($sformatf("cnt[%0d]", i), int'(co[i]), int'(e.c[i]));
                    check($sformatf("sat[%0d]", i), int'(so[i]), int'(e.s[i]));
                end
            end
        end
    end

    initial begin : driver
        for (int i = 0; i < NDUT; i++) begin
            hbits[i] = '0; hlen[i] = 0; cnt[i] = 0; mflag[i] = 1'b0;
        end
        do_reset();

        // 1101101 across overlap / non-overlap / Mealy
        bits(32'b110, 3);
        step(1'b0, 1'b1, 1'b1, 1'b0);
        #2;
        check("mealy_same_cycle", int'(mo[2]), 1);
        check("moore_not_yet", int'(mo[0]), 0);
        bits(32'b101, 3);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        #2;
        check("t1_ovl_cnt", int'(co[0]), 2);
        check("t1_novl_cnt", int'(co[1]), 1);
        check("t1_mealy_cnt", int'(co[2]), 2);
        check("t1_ovl_match", int'(mo[0]), 1);
        check("t1_novl_match", int'(mo[1]), 0);

        // gap in in_valid mid-pattern
        do_reset();
        bits(32'b110, 3);
        repeat (3) step(1'b0, 1'b0, 1'b1, 1'b0);
        bits(32'b1, 1);
        repeat (2) step(1'b0, 1'b0, 1'b0, 1'b0);
        #2;
        check("gap_hold_match", int'(mo[0]), 1);

        // reset mid-pattern discards the partial prefix
        do_reset();
        bits(32'b110, 3);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        #2;
        check("rst_mid_match", int'(mo[0]), 0);
        check("rst_mid_cnt", int'(co[0]), 0);

        // saturation of the 2-bit counter, then clear with a match
        do_reset();
        bits(32'b1101, 4);
        repeat (3) bits(32'b101, 3);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        #2;
        check("sat_cnt", int'(co[3]), 3);
        check("sat_flag", int'(so[3]), 1);
        bits(32'b10, 2);
        step(1'b0, 1'b1, 1'b1, 1'b1);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        #2;
        check("clr_match_cnt", int'(co[3]), 1);
        check("clr_match_sat", int'(so[3]), 0);

        repeat (4000) begin
            step(($urandom_range(299) == 0), ($urandom_range(3) != 0),
                 1'($urandom_range(1)), ($urandom_range(39) == 0));
        end

        @(negedge clk);
        #3;
        check("queue_drained", q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
